wb_master_engine: RTL and testbench
===================================

// Module: wb_master_engine
// PURPOSE
//   Wishbone classic single-transfer initiator. It converts a simple command
//   handshake (addr/data/we) into one CYC/STB bus cycle and returns read data,
//   or an error if ACK never arrives. It drives WB_Slave in front of the SRAM
//   controller and replaces bench-driven master stimulus in system builds.
// PARAMETERS
//   AW           32  Wishbone address width (ADR_O).
//   DW           32  Wishbone data width (DAT_O/DAT_I).
//   TIMEOUT_CYC  64  Max cycles STB may wait for ACK before abort; >=2.
// PORTS
//   CLK_I      in   1   clock, rising-edge
//   RST_I      in   1   synchronous reset, active-high
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   engine can accept command this cycle
//   cmd_we     in   1   1=write, 0=read
//   cmd_addr   in   AW  byte address
//   cmd_wdata  in   DW  write data (ignored on read)
//   rsp_valid  out  1   response present, held until rsp_ready
//   rsp_ready  in   1   consumer takes response
//   rsp_rdata  out  DW  read data captured from DAT_I (0 for writes/errors)
//   rsp_err    out  1   1=transfer timed out
//   ADR_O      out  AW  Wishbone address
//   DAT_O      out  DW  Wishbone write data
//   DAT_I      in   DW  Wishbone read data
//   WE_O       out  1   Wishbone write enable
//   STB_O      out  1   Wishbone strobe
//   CYC_O      out  1   Wishbone cycle
//   ACK_I      in   1   Wishbone acknowledge
// BEHAVIOUR
//   Reset (RST_I high at edge): state=IDLE; CYC_O=STB_O=WE_O=0; ADR_O=DAT_O=0;
//     rsp_valid=0, rsp_err=0, rsp_rdata=0; timeout counter=0; gap flag clear.
//   States:
//     IDLE: cmd_ready=1 unless gap flag is set. On cmd_valid&&cmd_ready, latch
//       we/addr/wdata into ADR_O/DAT_O/WE_O, set CYC_O=STB_O=1, go BUS.
//       The flag causes exactly one idle cycle after each transfer. The
//       flag clears on that cycle; STB_O stays low for >=1 cycle between
//       transfers, as WB_Slave requires.
//     BUS: CYC_O=STB_O=1. ADR_O/DAT_O/WE_O are held stable. The counter
//       increments each cycle without ACK.
//       ACK_I=1 at edge: drop CYC/STB next cycle. Capture DAT_I into rsp_rdata
//         if read, else load 0. Set rsp_err=0, rsp_valid=1, go RESP.
//       If the counter reaches TIMEOUT_CYC-1 with no ACK: drop CYC/STB. Set
//         rsp_err=1, rsp_rdata=0, rsp_valid=1, go RESP.
//       If ACK and timeout occur on the same edge, ACK wins (err=0).
//     RESP: CYC_O=STB_O=0. The response is held stable. On rsp_ready, clear
//       rsp_valid, set gap flag, clear counter, go IDLE.
//   Latency: command accept edge -> STB_O high the next cycle. ACK edge ->
//     rsp_valid high the next cycle. Minimum command-to-command: 4 cycles.
//   cmd_ready=0 in BUS/RESP; a cmd_valid held there waits (it is not dropped).
//   ACK_I while STB_O=0 is ignored, and it never creates a response.
//   Counter width $clog2(TIMEOUT_CYC)+1; it saturates and never wraps.
//   Reset mid-BUS: CYC/STB drop at that edge, no response emitted, and the
//     command is lost. Reset mid-RESP: the response is discarded.
// TESTING
//   Write: cmd we=1 addr=0xABCDABCD wdata=0xABCDEF12, slave ACK after 5 cyc
//     -> ADR_O/DAT_O stable for 5 cyc. rsp_valid with err=0.
//     SRAM[0x1ABCD..+3]=12,EF,CD,AB.
//   Read back: cmd we=0 addr=0xABCDABCD -> rsp_rdata=0xABCDEF12, err=0.
//     Then write/read 0x00000752 with 0x12345678 -> rsp_rdata=0x12345678.
//   Timeout: slave never ACKs, TIMEOUT_CYC=64 -> STB_O high exactly 64
//     cycles, then rsp_err=1, rsp_rdata=0, CYC_O=0.
//   ACK on terminal timeout cycle (ACK delay 63) -> rsp_err=0, data valid.
//   Backpressure: rsp_ready low 10 cycles, cmd_valid held -> rsp stable.
//     cmd_ready=0 throughout. Next STB rises >=2 cycles after rsp_ready.
//   Reset in BUS: RST_I high at cycle 3 of a write -> next cycle CYC_O=STB_O=0,
//     rsp_valid=0. A new command after reset completes normally.

Source files
------------

// File: rtl/wb_master_engine_if.sv
// Command/response handshake plus Wishbone classic bus for wb_master_engine.
// The master modport is the engine side; the slave modport is the surrounding system.
interface wb_master_engine_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O;
    logic [DW-1:0] DAT_I;
    logic          WE_O;
    logic          STB_O;
    logic          CYC_O;
    logic          ACK_I;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, DAT_I, ACK_I,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, ADR_O, DAT_O, WE_O, STB_O, CYC_O
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, DAT_I, ACK_I,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, ADR_O, DAT_O, WE_O, STB_O, CYC_O
    );
endinterface

// File: rtl/wb_master_engine.sv
// Wishbone classic single-transfer initiator: one CYC/STB cycle per command,
// returning read data or a timeout error when ACK never arrives.
//
// state  | meaning
// IDLE   | waiting for a command; one forced idle cycle after each transfer
// BUS    | CYC/STB asserted, waiting for ACK or timeout
// RESP   | response presented, waiting for rsp_ready
module wb_master_engine #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    wb_master_engine_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_TERM = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          gap;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic          we;
    logic          stb;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;

    assign bus.cmd_ready = (state == S_IDLE) && !gap;
    assign bus.ADR_O     = adr;
    assign bus.DAT_O     = dat;
    assign bus.WE_O      = we;
    assign bus.STB_O     = stb;
    assign bus.CYC_O     = stb;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            cnt       <= '0;
            gap       <= 1'b0;
            adr       <= '0;
            dat       <= '0;
            we        <= 1'b0;
            stb       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gap) begin
                        gap <= 1'b0;
                    end else if (bus.cmd_valid) begin
                        adr   <= bus.cmd_addr;
                        dat   <= bus.cmd_wdata;
                        we    <= bus.cmd_we;
                        stb   <= 1'b1;
                        cnt   <= '0;
                        state <= S_BUS;
                    end
                end
                S_BUS: begin
                    // ACK takes priority over a timeout landing on the same edge
                    if (bus.ACK_I) begin
                        stb       <= 1'b0;
                        rsp_rdata <= we ? '0 : bus.DAT_I;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt == CNT_TERM) begin
                        stb       <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        gap       <= 1'b1;
                        cnt       <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    stb   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine with a byte-wide SRAM slave model
// whose ACK position within each strobe is chosen per step.
module tb_wb_master_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    wb_master_engine_if #(.AW(32), .DW(32)) bus ();

    wb_master_engine #(.AW(32), .DW(32), .TIMEOUT_CYC(64)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:131071];
    int   ack_at    = 1000;
    logic force_ack = 1'b0;
    int   stb_cnt   = 0;
    int   run       = 0;
    int   last_len  = 0;
    int   unstable  = 0;
    logic [31:0] adr0, dat0;

    function automatic logic [31:0] rdw(input logic [31:0] a);
        return {mem[17'(a + 3)], mem[17'(a + 2)], mem[17'(a + 1)], mem[17'(a)]};
    endfunction

    assign bus.ACK_I = force_ack | (bus.STB_O && (stb_cnt == ack_at));

    always @(posedge clk) begin
        stb_cnt  <= bus.STB_O ? stb_cnt + 1 : 0;
        bus.DAT_I <= rdw(bus.ADR_O);
        if (bus.STB_O && bus.ACK_I && bus.WE_O) begin
            for (int i = 0; i < 4; i++) mem[17'(bus.ADR_O + 32'(i))] <= bus.DAT_O[8*i +: 8];
        end
    end

    // strobe length and address/data stability during each strobe
    always @(posedge clk) begin
        if (bus.STB_O) begin
            if (run == 0) begin
                adr0 <= bus.ADR_O;
                dat0 <= bus.DAT_O;
            end else if (bus.ADR_O !== adr0 || bus.DAT_O !== dat0) begin
                unstable <= unstable + 1;
            end
            run <= run + 1;
        end else if (run != 0) begin
            last_len <= run;
            run      <= 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept_in_time", 64'(n < 100), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output logic [31:0] rd, output logic err);
        int n;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_in_time"}, 64'(n < 200), 64'd1);
        chk({tag, "_cyc_low_in_resp"}, 64'(bus.CYC_O), 64'd0);
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_cleared"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          k;
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cyc", 64'(bus.CYC_O), 64'd0);
        chk("rst_stb", 64'(bus.STB_O), 64'd0);
        chk("rst_we", 64'(bus.WE_O), 64'd0);
        chk("rst_adr", 64'(bus.ADR_O), 64'd0);
        chk("rst_dat", 64'(bus.DAT_O), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // write with ACK in the fifth strobe cycle
        ack_at = 4;
        send_cmd(1'b1, 32'hABCDABCD, 32'hABCDEF12);
        chk("wr_stb_next_cycle", 64'(bus.STB_O), 64'd1);
        chk("wr_cyc", 64'(bus.CYC_O), 64'd1);
        chk("wr_we", 64'(bus.WE_O), 64'd1);
        chk("wr_adr", 64'(bus.ADR_O), 64'hABCDABCD);
        chk("wr_dat", 64'(bus.DAT_O), 64'hABCDEF12);
        chk("wr_busy_not_ready", 64'(bus.cmd_ready), 64'd0);
        wait_rsp("wr1", rd, err);
        chk("wr1_err", 64'(err), 64'd0);
        chk("wr1_rdata_zero", 64'(rd), 64'd0);
        chk("wr1_stb_len", 64'(last_len), 64'd5);
        chk("wr1_stable", 64'(unstable), 64'd0);
        chk("sram_1abcd", 64'(mem[17'h1ABCD]), 64'h12);
        chk("sram_1abce", 64'(mem[17'h1ABCE]), 64'hEF);
        chk("sram_1abcf", 64'(mem[17'h1ABCF]), 64'hCD);
        chk("sram_1abd0", 64'(mem[17'h1ABD0]), 64'hAB);

        ack_at = 2;
        send_cmd(1'b0, 32'hABCDABCD, 32'h0);
        chk("rd1_we_low", 64'(bus.WE_O), 64'd0);
        wait_rsp("rd1", rd, err);
        chk("rd1_rdata", 64'(rd), 64'hABCDEF12);
        chk("rd1_err", 64'(err), 64'd0);

        send_cmd(1'b1, 32'h00000752, 32'h12345678);
        wait_rsp("wr2", rd, err);
        chk("wr2_err", 64'(err), 64'd0);
        send_cmd(1'b0, 32'h00000752, 32'hFFFFFFFF);
        wait_rsp("rd2", rd, err);
        chk("rd2_rdata", 64'(rd), 64'h12345678);
        chk("rd2_err", 64'(err), 64'd0);

        // slave never acknowledges
        ack_at = 1000;
        send_cmd(1'b0, 32'hABCDABCD, 32'h0);
        wait_rsp("to", rd, err);
        chk("to_err", 64'(err), 64'd1);
        chk("to_rdata_zero", 64'(rd), 64'd0);
        chk("to_stb_len", 64'(last_len), 64'd64);

        // ACK lands on the terminal timeout cycle
        ack_at = 63;
        send_cmd(1'b0, 32'h00000752, 32'h0);
        wait_rsp("term", rd, err);
        chk("term_err", 64'(err), 64'd0);
        chk("term_rdata", 64'(rd), 64'h12345678);
        chk("term_stb_len", 64'(last_len), 64'd64);

        // response backpressure with the next command already waiting
        ack_at = 1;
        send_cmd(1'b1, 32'h00000100, 32'h0BADBEEF);
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 32'h00000752;
        bus.cmd_valid = 1'b1;
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("bp_rsp_in_time", 64'(k < 50), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_held", 64'(bus.rsp_valid), 64'd1);
            chk("bp_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
            chk("bp_stb_low", 64'(bus.STB_O), 64'd0);
        end
        chk("bp_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        k = 0;
        while (bus.STB_O !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        bus.cmd_valid = 1'b0;
        chk("bp_gap_cycles", 64'(k), 64'd2);
        chk("bp_held_cmd_adr", 64'(bus.ADR_O), 64'h00000752);
        wait_rsp("bp2", rd, err);
        chk("bp2_rdata", 64'(rd), 64'h12345678);
        chk("sram_100", 64'(rdw(32'h100)), 64'h0BADBEEF);

        // stray ACK while idle is ignored
        force_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        chk("stray_ack_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("stray_ack_no_cyc", 64'(bus.CYC_O), 64'd0);

        // reset in the third strobe cycle of a write
        ack_at = 1000;
        send_cmd(1'b1, 32'h00000010, 32'h00000055);
        @(negedge clk);
        @(negedge clk);
        chk("rstbus_stb_before", 64'(bus.STB_O), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstbus_cyc", 64'(bus.CYC_O), 64'd0);
        chk("rstbus_stb", 64'(bus.STB_O), 64'd0);
        chk("rstbus_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstbus_rsp_still_low", 64'(bus.rsp_valid), 64'd0);
        chk("rstbus_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        ack_at = 2;
        send_cmd(1'b1, 32'h00000020, 32'hCAFEF00D);
        wait_rsp("post_wr", rd, err);
        chk("post_wr_err", 64'(err), 64'd0);
        send_cmd(1'b0, 32'h00000020, 32'h0);
        wait_rsp("post_rd", rd, err);
        chk("post_rd_rdata", 64'(rd), 64'hCAFEF00D);
        chk("post_rd_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
